// File: rtl/matmul_pkg.sv
// Shared constants and state encoding for the 8x8 matrix-multiply blocks.
// The RAM, sequencer and datapath all size themselves from these values.
package matmul_pkg;

    localparam int DIM = 8;
    localparam int AW  = 6;
    localparam int IW  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/matmul_line_addr_gen.sv
// Combinational address vector for one row (col_mode=0) or one column (col_mode=1)
// of a DIM x DIM row-major matrix, one address per RAM read port.
module matmul_line_addr_gen
    import matmul_pkg::*;
(
    input  logic [IW-1:0]     idx,
    input  logic              col_mode,
    output logic [DIM*AW-1:0] addr
);

    always_comb begin
        addr = '0;
        for (int k = 0; k < DIM; k++) begin
            if (col_mode) begin
                addr[k*AW +: AW] = AW'(k * DIM) + AW'(idx);
            end else begin
                addr[k*AW +: AW] = AW'(idx) * AW'(DIM) + AW'(k);
            end
        end
    end

endmodule

// File: rtl/matmul_read_sequencer.sv
// Walks all (i,j) pairs row-major, presenting row i of A and column j of B per beat.
// Outputs are registered; a stalled beat holds until out_ready, then done pulses once.
module matmul_read_sequencer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DIM*AW-1:0] a_addr,
    output logic [DIM*AW-1:0] b_addr,
    output logic [IW-1:0]     out_row,
    output logic [IW-1:0]     out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [IW-1:0] IDX_MAX = IW'(DIM - 1);

    state_t            state_q, state_d;
    logic [IW-1:0]     i_q, i_d;
    logic [IW-1:0]     j_q, j_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DIM*AW-1:0] a_addr_q, a_addr_d;
    logic [DIM*AW-1:0] b_addr_q, b_addr_d;
    logic [DIM*AW-1:0] row_vec;
    logic [DIM*AW-1:0] col_vec;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            i_d     = '0;
            j_d     = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        i_d     = '0;
                        j_d     = '0;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (valid_q && out_ready) begin
                        if (last_q) begin
                            state_d = ST_DONE;
                            i_d     = '0;
                            j_d     = '0;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (j_q == IDX_MAX) begin
                            j_d = '0;
                            i_d = i_q + IW'(1);
                        end else begin
                            j_d = j_q + IW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    i_d     = '0;
                    j_d     = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Addresses are derived from the next indices so they line up with the registered beat.
    matmul_line_addr_gen u_row_gen (
        .idx      (i_d),
        .col_mode (1'b0),
        .addr     (row_vec)
    );

    matmul_line_addr_gen u_col_gen (
        .idx      (j_d),
        .col_mode (1'b1),
        .addr     (col_vec)
    );

    always_comb begin
        last_d   = valid_d && (i_d == IDX_MAX) && (j_d == IDX_MAX);
        a_addr_d = valid_d ? row_vec : '0;
        b_addr_d = valid_d ? col_vec : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
        end
    end

    assign out_valid = valid_q;
    assign a_addr    = a_addr_q;
    assign b_addr    = b_addr_q;
    assign out_row   = i_q;
    assign out_col   = j_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_matmul_read_sequencer.sv
// Directed bench for matmul_read_sequencer: beat-number model checked every cycle,
// plus literal address/timing pins for the beats and edges that matter.
module tb_matmul_read_sequencer;

    localparam int DIM = 8;
    localparam int AW  = 6;
    localparam int IW  = 3;
    localparam int NBEATS = DIM * DIM;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b1;
    logic              out_valid;
    logic [DIM*AW-1:0] a_addr;
    logic [DIM*AW-1:0] b_addr;
    logic [IW-1:0]     out_row;
    logic [IW-1:0]     out_col;
    logic              out_last;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    matmul_read_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 running on beat m_n, 2 done cycle.
    int m_mode = 0;
    int m_n    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_n    <= 0;
        end else if (abort) begin
            m_mode <= 0;
            m_n    <= 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode <= 1;
                m_n    <= 0;
            end
        end else if (m_mode == 1) begin
            if (out_ready) begin
                if (m_n == NBEATS - 1) begin
                    m_mode <= 2;
                    m_n    <= 0;
                end else begin
                    m_n <= m_n + 1;
                end
            end
        end else begin
            m_mode <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [DIM*AW-1:0] ea, eb;
            int row, col;
            bit v;
            v   = (m_mode == 1);
            row = v ? m_n / DIM : 0;
            col = v ? m_n % DIM : 0;
            ea  = '0;
            eb  = '0;
            if (v) begin
                for (int k = 0; k < DIM; k++) begin
                    ea[k*AW +: AW] = AW'(row * DIM + k);
                    eb[k*AW +: AW] = AW'(k * DIM + col);
                end
            end
            chk("cyc_valid", 64'(out_valid), 64'(v));
            chk("cyc_busy",  64'(busy),      64'(v));
            chk("cyc_done",  64'(done),      64'(m_mode == 2));
            chk("cyc_row",   64'(out_row),   64'(row));
            chk("cyc_col",   64'(out_col),   64'(col));
            chk("cyc_last",  64'(out_last),  64'(v && m_n == NBEATS - 1));
            chk("cyc_a",     64'(a_addr),    64'(ea));
            chk("cyc_b",     64'(b_addr),    64'(eb));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int done_cnt = 0;
    always @(negedge clk) if (done) done_cnt++;

    logic [DIM*AW-1:0] A0, B0, A9, B9, A63, B63;

    initial begin
        int cyc;
        int d0;
        A0  = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
        B0  = {6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8, 6'd0};
        A9  = {6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10, 6'd9, 6'd8};
        B9  = {6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9, 6'd1};
        A63 = {6'd63, 6'd62, 6'd61, 6'd60, 6'd59, 6'd58, 6'd57, 6'd56};
        B63 = {6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15, 6'd7};

        // 1. reset and idle
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("idle_valid", 64'(out_valid), 64'd0);
            chk("idle_a",     64'(a_addr),    64'd0);
            chk("idle_b",     64'(b_addr),    64'd0);
            chk("idle_busy",  64'(busy | done), 64'd0);
            tick();
        end

        // 2. full run, ready held high
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            if (cyc == 0)  begin chk("b0_a", 64'(a_addr), 64'(A0));  chk("b0_b", 64'(b_addr), 64'(B0)); end
            if (cyc == 9)  begin chk("b9_a", 64'(a_addr), 64'(A9));  chk("b9_b", 64'(b_addr), 64'(B9)); end
            if (cyc == 63) begin
                chk("b63_a",    64'(a_addr),   64'(A63));
                chk("b63_b",    64'(b_addr),   64'(B63));
                chk("b63_last", 64'(out_last), 64'd1);
            end
            tick(); cyc++;
        end
        chk("run_done_cycle", 64'(cyc), 64'd64);
        chk("run_done_busy",  64'(busy), 64'd0);
        tick();
        chk("after_done", 64'(done), 64'd0);

        // 3. backpressure at beat (2,5)
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            out_ready = !(cyc >= 21 && cyc <= 23);
            if (cyc >= 21 && cyc <= 24) begin
                chk("bp_row", 64'(out_row), 64'd2);
                chk("bp_col", 64'(out_col), 64'd5);
                chk("bp_a0",  64'(a_addr[AW-1:0]), 64'd16);
                chk("bp_b0",  64'(b_addr[AW-1:0]), 64'd5);
            end
            tick(); cyc++;
        end
        out_ready = 1'b1;
        chk("bp_done_cycle", 64'(cyc), 64'd67);
        tick();

        // 4a. start pulse mid-run is ignored
        start = 1'b1; tick(); start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            start = (cyc == 10);
            tick(); cyc++;
        end
        start = 1'b0;
        chk("ign_start_done_cycle", 64'(cyc), 64'd64);
        tick();

        // 4b. abort at beat (4,0)
        start = 1'b1; tick(); start = 1'b0;
        repeat (32) tick();
        chk("abort_row", 64'(out_row), 64'd4);
        chk("abort_col", 64'(out_col), 64'd0);
        d0 = done_cnt;
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_a",     64'(a_addr),    64'd0);
        repeat (70) tick();
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);

        // 4c. abort together with start in idle
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("abort_start_valid", 64'(out_valid), 64'd0);
        chk("abort_start_busy",  64'(busy),      64'd0);

        // 5. async reset mid-run at beat (3,3)
        start = 1'b1; tick(); start = 1'b0;
        repeat (27) tick();
        chk("pre_rst_row", 64'(out_row), 64'd3);
        chk("pre_rst_col", 64'(out_col), 64'd3);
        d0 = done_cnt;
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_a",     64'(a_addr),    64'd0);
        chk("rst_b",     64'(b_addr),    64'd0);
        chk("rst_rowcol", 64'({out_row, out_col}), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        #2 rst = 1'b0;
        tick();
        chk("rst_no_done", 64'(done_cnt - d0), 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_valid", 64'(out_valid), 64'd1);
        chk("restart_rc",    64'({out_row, out_col}), 64'd0);
        chk("restart_a",     64'(a_addr), 64'(A0));

        // 6. back-to-back: start in DONE ignored, start in next IDLE accepted
        cyc = 0;
        while (!done && cyc < 200) begin tick(); cyc++; end
        chk("b2b_first_done", 64'(cyc), 64'd64);
        start = 1'b1; tick();
        chk("b2b_done_start_ignored", 64'(out_valid), 64'd0);
        tick(); start = 1'b0;
        chk("b2b_second_valid", 64'(out_valid), 64'd1);
        chk("b2b_second_rc",    64'({out_row, out_col}), 64'd0);
        cyc = 0;
        while (!done && cyc < 200) begin tick(); cyc++; end
        chk("b2b_second_done", 64'(cyc), 64'd64);
        tick(); tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
